// File: rtl/bytes2bits_stream.sv
// Streaming byte-word to bit-beat serializer: one N_BYTES word in, BEATS beats of
// OUT_W bits out, LSB-first within each byte and byte 0 first.
module bytes2bits_stream #(
  parameter int N_BYTES = 4,
  parameter int OUT_W   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_BYTES-1:0][7:0] bytes_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [OUT_W-1:0]        bits_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    out_last_o,
  output logic                    busy_o
);

  localparam int WORD_W = N_BYTES * 8;
  localparam int BEATS  = WORD_W / OUT_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if (N_BYTES < 1 || OUT_W < 1 || (WORD_W % OUT_W) != 0) begin : gParamCheck
      $error("bytes2bits_stream: OUT_W must divide N_BYTES*8 and N_BYTES must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [WORD_W-1:0]   r_shift;
  logic [WORD_W-1:0]   w_shiftNext;
  logic [WORD_W-1:0]   w_shifted;
  logic [WORD_W-1:0]   w_flat;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cntNext;
  logic                w_valid;
  logic                w_last;
  logic                w_inReady;
  logic                w_inHs;
  logic                w_outHs;

  assign w_flat = bytes_i;

  // With a single beat per word there is nothing left after the first beat.
  generate
    if (BEATS > 1) begin : gShift
      assign w_shifted = {{OUT_W{1'b0}}, r_shift[WORD_W-1:OUT_W]};
    end else begin : gNoShift
      assign w_shifted = '0;
    end
  endgenerate

  assign w_valid   = (r_state == EMIT);
  assign w_last    = w_valid && (r_cnt == LAST_CNT);
  assign w_inReady = !w_valid || (w_last && out_ready_i);
  assign w_inHs    = in_valid_i && w_inReady;
  assign w_outHs   = w_valid && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_shift <= w_shiftNext;
      r_cnt   <= w_cntNext;
    end
  end

  // A new word may load on the same edge that the last beat of the previous one leaves.
  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shift;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_inHs) begin
          w_stateNext = EMIT;
          w_shiftNext = w_flat;
          w_cntNext   = '0;
        end
      end
      EMIT: begin
        if (w_outHs) begin
          if (w_last) begin
            w_cntNext = '0;
            if (w_inHs) begin
              w_stateNext = EMIT;
              w_shiftNext = w_flat;
            end else begin
              w_stateNext = IDLE;
              w_shiftNext = '0;
            end
          end else begin
            w_shiftNext = w_shifted;
            w_cntNext   = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_shiftNext = '0;
        w_cntNext   = '0;
      end
    endcase
  end

  assign in_ready_o  = w_inReady;
  assign bits_o      = r_shift[OUT_W-1:0];
  assign out_valid_o = w_valid;
  assign out_last_o  = w_last;
  assign busy_o      = w_valid;

endmodule

// File: doc/bytes2bits_stream.md
Name: bytes2bits_stream

Overview:
Streaming BytesToBits serializer, the inverse of the bits2bytes packer. It accepts one word of N_BYTES bytes per handshake and emits the same bits as a stream of OUT_W-bit beats. Bit order is LSB-first within each byte and byte 0 first; bit k of the stream is bit (k mod 8) of byte (k div 8). It sits between byte-oriented sources (hash/XOF output, ciphertext buffers) and bit-granular decode/decompress stages.

Parameters:
N_BYTES, 4, bytes per input word; must be at least 1.
OUT_W, 1, bits per output beat; must divide N_BYTES*8, checked by elaboration-time assertion.
BEATS (localparam), N_BYTES*8/OUT_W, output beats per input word.

Ports:
clk_i  input  1  clock, all logic on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
bytes_i  input  [N_BYTES-1:0][7:0]  input word; bytes_i[j] is byte j.
in_valid_i  input  1  bytes_i is valid.
in_ready_o  output  1  block can accept a word this cycle.
bits_o  output  OUT_W  current beat; bits_o[m] is stream bit (beat*OUT_W + m).
out_valid_o  output  1  bits_o is valid.
out_ready_i  input  1  downstream accepts the beat.
out_last_o  output  1  current beat is beat BEATS-1 of the word.
busy_o  output  1  a word is held (equals out_valid_o).

Behaviour:
- Reset (rst_i=1, asynchronous): shift register, beat counter and valid are cleared. bits_o=0, out_valid_o=0, out_last_o=0, busy_o=0, in_ready_o=1 after reset is released. A word in flight is discarded with no partial output.
- States: IDLE (no word held) and EMIT (word held, beat counter cnt in 0..BEATS-1).
- in_ready_o = !out_valid_o || (out_last_o && out_ready_i). This is combinational on out_ready_i, so back-to-back words have no bubble.
- Input handshake is in_valid_i && in_ready_o. On handshake, the flattened bytes_i is loaded into the shift register, cnt=0 and out_valid_o=1 on the next edge. Input latency is 1 cycle: the first beat is visible the cycle after the handshake.
- bits_o = shift_reg[OUT_W-1:0]. It is registered, not combinational from bytes_i.
- out_last_o = out_valid_o && (cnt == BEATS-1).
- Output handshake is out_valid_o && out_ready_i.
  - When not last: shift_reg shifts right by OUT_W with zero fill, and cnt increments.
  - When last with a simultaneous input handshake: the new word loads, cnt=0 and out_valid_o stays 1.
  - When last without an input handshake: out_valid_o goes to 0, the block returns to IDLE and shift_reg clears to 0.
- Backpressure: while out_valid_o && !out_ready_i, bits_o, out_last_o and cnt hold stable. in_valid_i is ignored until the last beat is accepted.
- in_valid_i while busy and not on the last beat: no load, bytes_i is not sampled, and the source must hold it.
- BEATS=1 (OUT_W=N_BYTES*8): every beat is last, and the block acts as a 1-deep registered pipeline stage with full throughput.
- cnt width is $clog2(BEATS), minimum 1 bit. cnt never exceeds BEATS-1; on the last beat it wraps to 0.
- No data-dependent behaviour; all zero and all one words are handled identically.
- Throughput: one word per BEATS cycles with out_ready_i held high.

Test Plan:
- Reset mid-word: N_BYTES=4, OUT_W=4, load 0x89ABCDEF, accept 3 beats, assert rst_i asynchronously between edges -> out_valid_o=0, bits_o=0 immediately; after release in_ready_o=1 and the next word streams from its beat 0.
- Nibble order: N_BYTES=4, OUT_W=4, bytes_i={89,AB,CD,EF} (byte0=EF), out_ready_i=1 -> beats F,E,D,C,B,A,9,8 on 8 consecutive cycles starting 1 cycle after the handshake; out_last_o only with 8.
- Bit order, default params: byte0=0xEF, others 0x00 -> first 8 bits_o 1,1,1,1,0,1,1,1, then 24 zeros; out_last_o on beat 31.
- Backpressure: OUT_W=4, drop out_ready_i for 5 cycles on beat 2 -> bits_o stays D and cnt stays 2; in_ready_o=0 throughout; the sequence resumes with no loss or duplication.
- Back-to-back: two words 0x00000000 and 0xFFFFFFFF with in_valid_i held -> second handshake coincides with beat 7 of the first; output is 8 beats of 0 then 8 beats of F with no gap cycle.
- Round-trip/random: feed 5 random words through bytes2bits_stream then bits2bytes (after collecting the beats) -> each reconstructed word equals its input; pass count 5/5.
